// File: rtl/mod_n_pkg.sv
// Shared definitions for the mod-n counter family: parameter legality,
// prescaler width and the wrap-count width.
package mod_n_pkg;

   localparam int unsigned WRAP_CNT_W = 8;

   // True when modulus, width and prescale form a buildable counter.
   function automatic bit mod_n_params_ok(input int unsigned n, input int unsigned w,
                                          input int unsigned prescale);
      return (w >= 1) && (w <= 31) && (n >= 2) && (64'(n) <= (64'd1 << w)) && (prescale >= 1);
   endfunction

   // Bits needed to hold 0..p-1, never less than one.
   function automatic int unsigned prescale_w(input int unsigned p);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(p)) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/mod_n_tick_gen.sv
// Enable prescaler: tick is high on every PRESCALE-th enabled clock.
// sync_zero restarts the prescale window; PRESCALE=1 reduces to tick=en.
module mod_n_tick_gen
   import mod_n_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sync_zero,
   output logic tick
);

   localparam int unsigned PW = prescale_w(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (sync_zero) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + PW'(1);
      end
   end

endmodule

// File: rtl/mod_n_up_counter.sv
// Modulo-n up counter with prescaled enable, clear, range-checked load,
// terminal-count and wrap flags. MOD_N_UP_COUNTER_WRAP_CNT_EN adds wrap_cnt.
module mod_n_up_counter
   import mod_n_pkg::*;
#(
   parameter int unsigned n        = 10,
   parameter int unsigned N        = 4,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic                  load,
   input  logic [N-1:0]          din,
   output logic [N-1:0]          out,
   output logic                  tc,
   output logic                  wrap,
`ifdef MOD_N_UP_COUNTER_WRAP_CNT_EN
   output logic [WRAP_CNT_W-1:0] wrap_cnt,
`endif
   output logic                  load_err
);

   localparam logic [N-1:0] LAST    = N'(n - 1);
   localparam logic [N:0]   MOD_EXT = (N+1)'(n);

   if (!mod_n_params_ok(n, N, PRESCALE)) begin : g_param_err
      $error("mod_n_up_counter: illegal parameters n=%0d N=%0d PRESCALE=%0d", n, N, PRESCALE);
   end

   logic tick;
   logic din_ok;

   assign din_ok = ({1'b0, din} < MOD_EXT);
   assign tc     = (out == LAST);

   // clr or load restarts the prescale window so the next tick is a full period away
   mod_n_tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sync_zero (clr | load),
      .tick      (tick)
   );

   // Command priority: clear, then load, then count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out      <= '0;
         wrap     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         wrap     <= 1'b0;
         load_err <= 1'b0;
         if (clr) begin
            out <= '0;
         end else if (load) begin
            out      <= din_ok ? din : '0;
            load_err <= !din_ok;
         end else if (tick) begin
            if (out == LAST) begin
               out  <= '0;
               wrap <= 1'b1;
            end else begin
               out <= out + N'(1);
            end
         end
      end
   end

`ifdef MOD_N_UP_COUNTER_WRAP_CNT_EN
   // Saturating wrap-event counter; load leaves it alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrap_cnt <= '0;
      end else if (clr) begin
         wrap_cnt <= '0;
      end else if (!load && tick && (out == LAST) && (wrap_cnt != '1)) begin
         wrap_cnt <= wrap_cnt + WRAP_CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_mod_n_up_counter.sv
// Scoreboard bench for mod_n_up_counter: instance a (n=10, PRESCALE=1) and
// instance b (n=10, PRESCALE=3). Drivers queue expectations; a monitor checks.
module tb_mod_n_up_counter;

   typedef struct {
      int unsigned due;
      bit          sel;
      logic [3:0]  out;
      logic        tc;
      logic        wrap;
      logic        lerr;
      logic [7:0]  wc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       a_en = 0, a_clr = 0, a_load = 0;
   logic [3:0] a_din = '0;
   logic [3:0] a_out;
   logic       a_tc, a_wrap, a_lerr;
   logic       b_en = 0, b_clr = 0, b_load = 0;
   logic [3:0] b_din = '0;
   logic [3:0] b_out;
   logic       b_tc, b_wrap, b_lerr;
   logic [7:0] a_wc = '0;
   logic [7:0] b_wc = '0;

   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int unsigned exp_wc = 0;
   exp_t        sb[$];
   exp_t        e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mod_n_up_counter #(.n(10), .N(4), .PRESCALE(1)) dut_a (
      .clk (clk), .rst (rst), .en (a_en), .clr (a_clr), .load (a_load), .din (a_din),
      .out (a_out), .tc (a_tc), .wrap (a_wrap),
`ifdef MOD_N_UP_COUNTER_WRAP_CNT_EN
      .wrap_cnt (a_wc),
`endif
      .load_err (a_lerr)
   );

   mod_n_up_counter #(.n(10), .N(4), .PRESCALE(3)) dut_b (
      .clk (clk), .rst (rst), .en (b_en), .clr (b_clr), .load (b_load), .din (b_din),
      .out (b_out), .tc (b_tc), .wrap (b_wrap),
`ifdef MOD_N_UP_COUNTER_WRAP_CNT_EN
      .wrap_cnt (b_wc),
`endif
      .load_err (b_lerr)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, expv);
      end
   endtask

   // Monitor: every sampled cycle, compare the entries due now.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         if (e.due != cyc) begin
            chk("missed_sample", cyc, e.due);
         end else if (!e.sel) begin
            chk("a.out", 32'(a_out), 32'(e.out));
            chk("a.tc", 32'(a_tc), 32'(e.tc));
            chk("a.wrap", 32'(a_wrap), 32'(e.wrap));
            chk("a.load_err", 32'(a_lerr), 32'(e.lerr));
`ifdef MOD_N_UP_COUNTER_WRAP_CNT_EN
            chk("a.wrap_cnt", 32'(a_wc), 32'(e.wc));
`endif
         end else begin
            chk("b.out", 32'(b_out), 32'(e.out));
            chk("b.tc", 32'(b_tc), 32'(e.tc));
            chk("b.wrap", 32'(b_wrap), 32'(e.wrap));
            chk("b.load_err", 32'(b_lerr), 32'(e.lerr));
         end
      end
   end

   task automatic drive_a(input logic en, input logic clr, input logic load, input logic [3:0] din,
                          input logic [3:0] eo, input logic ew, input logic el);
      exp_t x;
      @(posedge clk); #1;
      a_en = en; a_clr = clr; a_load = load; a_din = din;
      if (clr) exp_wc = 0;
      else if (ew && exp_wc != 255) exp_wc++;
      x.due = cyc + 1; x.sel = 1'b0; x.out = eo; x.tc = (eo == 4'd9);
      x.wrap = ew; x.lerr = el; x.wc = 8'(exp_wc);
      sb.push_back(x);
   endtask

   task automatic drive_b(input logic en, input logic load, input logic [3:0] din,
                          input logic [3:0] eo);
      exp_t x;
      @(posedge clk); #1;
      b_en = en; b_clr = 1'b0; b_load = load; b_din = din;
      x.due = cyc + 1; x.sel = 1'b1; x.out = eo; x.tc = (eo == 4'd9);
      x.wrap = 1'b0; x.lerr = 1'b0; x.wc = '0;
      sb.push_back(x);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, ".a.out"}, 32'(a_out), 0);
      chk({tag, ".a.tc"}, 32'(a_tc), 0);
      chk({tag, ".a.wrap"}, 32'(a_wrap), 0);
      chk({tag, ".a.load_err"}, 32'(a_lerr), 0);
      chk({tag, ".b.out"}, 32'(b_out), 0);
      chk({tag, ".b.tc"}, 32'(b_tc), 0);
`ifdef MOD_N_UP_COUNTER_WRAP_CNT_EN
      chk({tag, ".a.wrap_cnt"}, 32'(a_wc), 0);
`endif
   endtask

   initial begin
      #1 rst = 1'b0;
      #50 check_reset_state("reset");
      #49 rst = 1'b1;

      // Basic count 0..9,0,1 with wrap after 9->0
      for (int k = 1; k <= 11; k++) drive_a(1, 0, 0, 0, 4'(k % 10), k == 10, 0);
      drive_a(0, 0, 0, 0, 4'd1, 0, 0);
      drive_a(0, 0, 0, 0, 4'd1, 0, 0);
      // Loads, including the n and 2^N-1 boundaries
      drive_a(0, 0, 1, 4'd7,  4'd7, 0, 0);
      drive_a(0, 0, 1, 4'd12, 4'd0, 0, 1);
      drive_a(0, 0, 0, 4'd0,  4'd0, 0, 0);
      drive_a(0, 0, 1, 4'd10, 4'd0, 0, 1);
      drive_a(0, 0, 1, 4'd15, 4'd0, 0, 1);
      drive_a(0, 0, 1, 4'd9,  4'd9, 0, 0);
      drive_a(1, 0, 0, 4'd0,  4'd0, 1, 0);
      drive_a(0, 0, 0, 4'd0,  4'd0, 0, 0);
      // Priority: clear beats load, load beats tick
      drive_a(0, 0, 1, 4'd4,  4'd4, 0, 0);
      drive_a(0, 1, 1, 4'd5,  4'd0, 0, 0);
      drive_a(0, 0, 1, 4'd8,  4'd8, 0, 0);
      drive_a(0, 1, 1, 4'd13, 4'd0, 0, 0);
      drive_a(0, 0, 1, 4'd9,  4'd9, 0, 0);
      drive_a(1, 0, 1, 4'd3,  4'd3, 0, 0);
      drive_a(1, 1, 0, 4'd0,  4'd0, 0, 0);
      drive_a(1, 0, 1, 4'd3,  4'd3, 0, 0);
      drive_a(1, 0, 0, 4'd0,  4'd4, 0, 0);
      drive_a(1, 0, 0, 4'd0,  4'd5, 0, 0);
      drive_a(1, 0, 0, 4'd0,  4'd6, 0, 0);

      // Async reset between edges while out=6
      @(posedge clk); @(negedge clk); #1;
      rst = 1'b0; a_en = 1'b0;
      #1 check_reset_state("async_rst_a");
      exp_wc = 0;
      #2 rst = 1'b1;
      drive_a(1, 0, 0, 4'd0, 4'd1, 0, 0);
      drive_a(0, 0, 0, 4'd0, 4'd1, 0, 0);

      // Prescale by 3: one advance per three enabled clocks
      for (int k = 1; k <= 9; k++) drive_b(1, 0, 4'd0, 4'(k / 3));
      for (int k = 0; k < 5; k++) drive_b(0, 0, 4'd0, 4'd3);
      drive_b(1, 0, 4'd0, 4'd3);
      drive_b(0, 1, 4'd5, 4'd5);
      drive_b(1, 0, 4'd0, 4'd5);
      drive_b(1, 0, 4'd0, 4'd5);
      drive_b(1, 0, 4'd0, 4'd6);
      drive_b(1, 0, 4'd0, 4'd6);

      // Async reset mid-prescale: the partial window must not survive
      @(posedge clk); @(negedge clk); #1;
      rst = 1'b0; b_en = 1'b0;
      #1 chk("async_rst_b.out", 32'(b_out), 0);
      #2 rst = 1'b1;
      drive_b(1, 0, 4'd0, 4'd0);
      drive_b(1, 0, 4'd0, 4'd0);
      drive_b(1, 0, 4'd0, 4'd1);
      drive_b(0, 0, 4'd0, 4'd1);

`ifdef MOD_N_UP_COUNTER_WRAP_CNT_EN
      // 300 wraps saturate wrap_cnt at 255; clr returns it to 0
      drive_a(0, 1, 0, 4'd0, 4'd0, 0, 0);
      for (int k = 1; k <= 3000; k++) drive_a(1, 0, 0, 4'd0, 4'(k % 10), (k % 10) == 0, 0);
      drive_a(0, 0, 1, 4'd2, 4'd2, 0, 0);
      drive_a(0, 1, 0, 4'd0, 4'd0, 0, 0);
`endif

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1 chk("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod_n_up_counter.md
# mod_n_up_counter

Synchronous modulo-n up counter: the incrementing counterpart of the existing mod-n down counter, with the same `clk`/`rst`/`out` naming and parameter style. The block counts 0, 1, …, n-1, 0, … under a prescaled enable. It adds synchronous clear, parallel load with range checking, terminal-count and wrap flags, so it can be cascaded into multi-digit counters and timers.

## Interface
- `n`, default 10: modulus; legal range 2..2^N.
- `N`, default 4: counter width in bits.
- `PRESCALE`, default 1: the count advances once every PRESCALE enabled clocks; 1 means every enabled clock.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: count enable. Also gates the prescaler.
- `clr`, input, 1: synchronous clear.
- `load`, input, 1: synchronous parallel load strobe.
- `din`, input, N: load value.
- `out`, output, N: current count, registered.
- `tc`, output, 1: terminal count. Combinational; high when `out == n-1`.
- `wrap`, output, 1: registered one-cycle pulse; high in the cycle after `out` advances from n-1 to 0.
- `load_err`, output, 1: registered one-cycle pulse; high in the cycle after a load with `din >= n`.

## Operation
- Command priority, evaluated every rising edge: `clr` > `load` > count.
- `clr`: out←0, prescaler←0, wrap←0.
- `load`:
  - If `din < n`: out←din.
  - If `din >= n`: out←0 and load_err←1.
  - In both cases the prescaler←0.
- Count:
  - With `en`=1 the prescaler increments modulo PRESCALE.
  - A tick occurs on the edge where the prescaler equals PRESCALE-1. With PRESCALE=1, every enabled edge is a tick.
  - On a tick: if out==n-1 then out←0 and wrap←1; otherwise out←out+1.
- With `en`=0, `out` and the prescaler hold. wrap and load_err deassert on the next edge.
- Arithmetic is unsigned N-bit. `out` never holds a value ≥ n.
- Elaboration error if n<2, n>2^N, or PRESCALE<1.
- Cascading: the next stage's `en` is driven from `tc & en` of this stage (PRESCALE=1).

## Timing
- Reset (rst=0, asynchronous): out=0, wrap=0, load_err=0, prescaler=0, so tc=0. Outputs are valid immediately, without waiting for a clock edge.
- Reset release: the first count edge is the first rising edge with rst=1 and en=1.
- Latency:
  - clr/load to `out`: 1 clock.
  - Tick to `out`: 1 clock.
  - `tc` follows `out` combinationally.
- wrap and load_err are exactly one clock wide and never assert together.
- Simultaneous clr+load: clear wins and load_err stays 0.
- Simultaneous load with tick: load wins and wrap stays 0, even if out was n-1.
- Reset asserted mid-count or mid-prescale: all state returns to reset values at once; no partial tick survives.

## Configuration
- `MOD_N_UP_COUNTER_WRAP_CNT_EN`:
  - Defined: adds output `wrap_cnt` [7:0], reset 0.
    - Increments on each wrap event, saturating at 255.
    - Cleared by `clr`; not affected by `load`.
  - Undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- Shared package `mod_n_pkg` holds:
  - the parameter legality check function;
  - a `clog2`-style width function for the prescaler;
  - the localparam `WRAP_CNT_W = 8`.
  - The existing down counter's testbench reuses this package.
- One sub-module, `mod_n_tick_gen`: the prescaler.
  - Inputs: clk, rst, en, sync_zero.
  - Output: tick.
  - Parameter: PRESCALE.
  - With PRESCALE=1 it degenerates to tick=en.

## Test plan
- Reset/basic count (n=10, N=4, PRESCALE=1): hold rst=0 for 100 ns, release, en=1.
  - Expected: out = 0,1,…,9,0; tc high only at 9; wrap high for 1 clock after 9→0.
- Prescale: PRESCALE=3, en=1 for 9 clocks.
  - Expected: out advances 0→1→2→3, once per 3 clocks; hold en=0 for 5 clocks and out stays 3.
- Load:
  - load din=7: out=7 next clock, load_err=0.
  - load din=12: out=0, load_err=1 for 1 clock.
  - load din=9 then count: out 9→0 with wrap=1.
- Priority:
  - clr=1 and load=1 with din=5: out=0, load_err=0.
  - load din=3 at out=9 during a tick: out=3, wrap=0.
- Async reset mid-operation: pull rst low between clock edges while out=6.
  - Expected: out=0 immediately, and tc, wrap, load_err all 0.
- Wrap count (macro defined): 300 full wraps.
  - Expected: wrap_cnt saturates at 255; clr returns it to 0.
